// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the Wishbone initiator
package wb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int SEL_WIDTH          = DEFAULT_DATA_WIDTH / 8;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction
endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - Wishbone classic bus bundle; dat_i is write data, dat_o is read data
interface wishbone_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
) (
    input logic clk_i,
    input logic rst_i
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic                    ack;
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH/8-1:0] sel;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic [DATA_WIDTH-1:0]   dat_o;

    modport master (
        input  clk_i, rst_i, ack, dat_o,
        output cyc, stb, we, adr, sel, dat_i
    );

    modport slave (
        input  clk_i, rst_i, cyc, stb, we, adr, sel, dat_i,
        output ack, dat_o
    );
endinterface

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - saturating clear/enable counter flagging its last allowed cycle
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic at_limit
);
    localparam int            W   = cnt_width(LIMIT);
    localparam logic [W-1:0]  SAT = W'(LIMIT);
    localparam logic [W-1:0]  TOP = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && count != SAT) begin
            count <= count + 1'b1;
        end
    end

    // A zero limit disables the flag entirely.
    assign at_limit = (LIMIT != 0) && (count == TOP);
endmodule

// File: rtl/wb_master_port.sv
// rtl/wb_master_port.sv - single-outstanding Wishbone classic initiator with timeout abort
module wb_master_port
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    wishbone_if.master              wb,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);
    wb_state_t state;
    logic      tmo_hit;

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk      (wb.clk_i),
        .rst      (wb.rst_i),
        .clr      (state == ST_IDLE),
        .en       ((state == ST_BUS) && !wb.ack),
        .at_limit (tmo_hit)
    );

    assign req_ready = (state == ST_IDLE) && !wb.rst_i;

    always_ff @(posedge wb.clk_i) begin
        if (wb.rst_i) begin
            state     <= ST_IDLE;
            wb.cyc    <= 1'b0;
            wb.stb    <= 1'b0;
            wb.we     <= 1'b0;
            wb.adr    <= '0;
            wb.sel    <= '0;
            wb.dat_i  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        wb.we    <= req_we;
                        wb.adr   <= req_addr;
                        wb.sel   <= req_sel;
                        wb.dat_i <= req_wdata;
                        wb.cyc   <= 1'b1;
                        wb.stb   <= 1'b1;
                        state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (wb.ack) begin
                        rsp_rdata <= wb.we ? '0 : wb.dat_o;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        wb.cyc    <= 1'b0;
                        wb.stb    <= 1'b0;
                        state     <= ST_RESP;
                    end else if (tmo_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        wb.cyc    <= 1'b0;
                        wb.stb    <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_port.sv
// tb/tb_wb_master_port.sv - self-checking bench for wb_master_port with a latency-programmable slave
module tb_wb_master_port;
    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [19:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    wishbone_if #(.ADDR_WIDTH(20), .DATA_WIDTH(32)) wb (.clk_i(clk), .rst_i(rst));

    wb_master_port #(
        .ADDR_WIDTH     (20),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb        (wb.master),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave: acks combinationally in the ack_lat-th cycle that stb is high.
    logic [31:0] slv_mem [64];
    logic        mem_init;
    int          stb_cnt;
    int          ack_lat;

    assign wb.ack   = wb.cyc && wb.stb && (stb_cnt == ack_lat - 1);
    assign wb.dat_o = slv_mem[wb.adr[7:2]];

    always @(posedge clk) begin
        if (!wb.cyc) stb_cnt <= 0;
        else         stb_cnt <= stb_cnt + 1;
        if (mem_init) begin
            for (int i = 0; i < 64; i++) slv_mem[i] <= '0;
        end else if (wb.cyc && wb.stb && wb.ack && wb.we) begin
            for (int b = 0; b < 4; b++)
                if (wb.sel[b]) slv_mem[wb.adr[7:2]][8*b +: 8] <= wb.dat_i[8*b +: 8];
        end
    end

    // Transaction-level reference: words of memory, byte-lane merge, latency vs timeout.
    logic [31:0] model_mem [64];

    task automatic model_txn(input logic we, input logic [19:0] addr, input logic [31:0] wdata,
                             input logic [3:0] sel, input int lat,
                             output logic [31:0] rdata, output logic err, output int ncyc);
        logic [31:0] w;
        err  = (lat > TMO);
        ncyc = err ? TMO : lat;
        w    = model_mem[addr[7:2]];
        if (!err && we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = wdata[8*b +: 8];
            model_mem[addr[7:2]] = w;
        end
        rdata = (we || err) ? 32'h0 : w;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic scramble_req();
        req_we    = 1'($urandom);
        req_addr  = 20'($urandom);
        req_wdata = $urandom;
        req_sel   = 4'($urandom);
    endtask

    task automatic run_txn(input logic we, input logic [19:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel, input int lat, input int hold,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_cyc,
                           input string tag);
        int          n;
        int          cyc_cnt;
        int          w;
        logic        seen;
        logic        stable;
        logic        held_ok;
        logic [31:0] rd;
        logic        er;
        ack_lat   = lat;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_sel   = sel;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " accept"}, {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        scramble_req();
        cyc_cnt = 0;
        seen    = 1'b0;
        stable  = 1'b1;
        n       = 1;
        while (n <= 40) begin
            if (wb.cyc) begin
                cyc_cnt++;
                if (!wb.stb || wb.adr !== addr || wb.sel !== sel || wb.we !== we || wb.dat_i !== wdata)
                    stable = 1'b0;
            end
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        chk({tag, " rsp_seen"}, {31'b0, seen}, 32'h1);
        chk({tag, " rsp_latency"}, 32'(n), 32'(exp_cyc + 1));
        chk({tag, " cyc_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
        chk({tag, " bus_stable"}, {31'b0, stable}, 32'h1);
        chk({tag, " cyc_low_at_rsp"}, {30'b0, wb.cyc, wb.stb}, 32'h0);
        chk({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, " rsp_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        rd = rsp_rdata;
        er = rsp_err;
        held_ok = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clk);
            if (req_ready || !rsp_valid || rsp_rdata !== rd || rsp_err !== er || wb.cyc) held_ok = 1'b0;
        end
        if (hold > 0) chk({tag, " rsp_held"}, {31'b0, held_ok}, 32'h1);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " rsp_cleared"}, {31'b0, rsp_valid}, 32'h0);
        chk({tag, " ready_after"}, {31'b0, req_ready}, 32'h1);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          lat;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] m_rd;
        logic        m_err;
        int          m_cyc;
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          lat;

        vecs[0] = '{1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 2,   0, 32'h0,        1'b0, 2};
        vecs[1] = '{1'b0, 20'h00010, 32'h0,        4'hF, 2,   0, 32'hDEADBEEF, 1'b0, 2};
        vecs[2] = '{1'b1, 20'h00010, 32'h000000AA, 4'h1, 2,   0, 32'h0,        1'b0, 2};
        vecs[3] = '{1'b0, 20'h00010, 32'h0,        4'hF, 3,   5, 32'hDEADBEAA, 1'b0, 3};
        vecs[4] = '{1'b0, 20'h00010, 32'h0,        4'hF, 100, 0, 32'h0,        1'b1, 8};
        vecs[5] = '{1'b0, 20'h00010, 32'h0,        4'hF, 8,   0, 32'hDEADBEAA, 1'b0, 8};
        vecs[6] = '{1'b1, 20'h00023, 32'h12345678, 4'hA, 1,   0, 32'h0,        1'b0, 1};
        vecs[7] = '{1'b0, 20'h00020, 32'h0,        4'hF, 1,   0, 32'h12005600, 1'b0, 1};
        vecs[8] = '{1'b1, 20'h00020, 32'hFFFFFFFF, 4'hF, 9,   0, 32'h0,        1'b1, 8};
        vecs[9] = '{1'b0, 20'h00021, 32'h0,        4'h3, 4,   2, 32'h12005600, 1'b0, 4};

        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        ack_lat   = 100;
        mem_init  = 1'b1;
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        scramble_req();

        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'h0);
        chk("reset_bus", {27'b0, wb.cyc, wb.stb, wb.we, 2'b0}, 32'h0);
        chk("reset_adr_sel", {8'b0, wb.adr, wb.sel}, 32'h0);
        chk("reset_dat_i", wb.dat_i, 32'h0);
        chk("reset_rsp", {30'b0, rsp_valid, rsp_err}, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        rst      = 1'b0;
        mem_init = 1'b0;
        #1;
        chk("ready_after_reset", {31'b0, req_ready}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, vecs[i].lat, m_rd, m_err, m_cyc);
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, vecs[i].lat, vecs[i].hold,
                    vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_cyc, $sformatf("vec%0d", i));
        end

        // Reset pulse while the bus is stalled on a non-acking slave.
        ack_lat   = 100;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 20'h00030;
        req_wdata = 32'hCAFEF00D;
        req_sel   = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_cyc_before", {31'b0, wb.cyc}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bus", {30'b0, wb.cyc, wb.stb}, 32'h0);
        chk("midrst_ready_in_reset", {31'b0, req_ready}, 32'h0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", {31'b0, req_ready}, 32'h1);
        begin
            logic quiet = 1'b1;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (rsp_valid || wb.cyc) quiet = 1'b0;
            end
            chk("midrst_no_stale_rsp", {31'b0, quiet}, 32'h1);
        end

        for (int i = 0; i < 40; i++) begin
            we    = 1'($urandom);
            addr  = 20'($urandom);
            wdata = $urandom;
            sel   = 4'($urandom_range(1, 15));
            lat   = $urandom_range(1, 10);
            model_txn(we, addr, wdata, sel, lat, m_rd, m_err, m_cyc);
            run_txn(we, addr, wdata, sel, lat, $urandom_range(0, 3), m_rd, m_err, m_cyc,
                    $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
